pipe_stage_elastic: RTL and testbench
=====================================

Name: pipe_stage_elastic

Overview:
Parametrised successor to the fixed inter-stage pipeline latches, usable for IF/ID, ID/EX, EX/MEM and MEM/WB.
- Carries a packed payload bus plus a packed control bus between two pipeline stages.
- Adds valid/ready handshaking, stall back-pressure through a 2-entry skid buffer, and synchronous flush (bubble insertion).
- Control outputs are forced to zero whenever the stage holds a bubble, so downstream reg_write/mem_write/branch/jump never fire spuriously.

Parameters:
DATA_W, 32, width of payload bus (pc, alu_result, rd2, imm, inst etc. packed by instantiator)
CTRL_W, 16, width of control bus (jump, mem_read, branch, mem_to_reg, mem_write, reg_write, zero, write_reg packed)
CNT_W, 32, width of performance counters (optional feature only)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
flush  input  1  synchronous flush: discard all held entries
in_valid  input  1  upstream has a valid entry
in_ready  output  1  stage can accept an entry this cycle
in_data  input  DATA_W  upstream payload
in_ctrl  input  CTRL_W  upstream control
out_valid  output  1  stage presents a valid entry
out_ready  input  1  downstream accepts this cycle
out_data  output  DATA_W  head payload
out_ctrl  output  CTRL_W  head control; all-zero when out_valid=0
occupancy  output  2  entries held: 0, 1 or 2

Behaviour:
- Single clock; reset is synchronous and active-high. All state changes occur only on the rising edge of clk.
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (head) plus skid register, each with a valid bit. State is encoded as EMPTY, ONE or TWO.
- Outputs:
  - in_ready = (state != TWO); registered, with no combinational path from out_ready.
  - out_valid = (state != EMPTY).
  - out_data = main data.
  - out_ctrl = main ctrl when out_valid, else 0.
  - occupancy reflects the state.
- Transitions, in priority order:
  1. rst → EMPTY, both data registers and both ctrl registers cleared to 0.
  2. flush → EMPTY, ctrl registers cleared, data registers hold their value; in_data is NOT captured even if in_fire.
  3. EMPTY: in_fire → ONE, main <= in.
  4. ONE:
     - in_fire & out_fire → ONE, main <= in.
     - in_fire & !out_ready → TWO, skid <= in.
     - !in_fire & out_fire → EMPTY.
     - otherwise hold.
  5. TWO: out_fire → ONE, main <= skid; otherwise hold. in_ready=0, so no input is accepted.
- Latency: an entry written into EMPTY appears at the outputs 1 cycle later.
- Throughput: 1 entry/cycle when out_ready is held high.
- Ordering is strictly FIFO; no entry is dropped or duplicated except by flush or rst.
- Stall: out_ready=0 holds out_data/out_ctrl stable while out_valid=1, and the stage absorbs exactly one further entry before deasserting in_ready.
- Reset mid-stream: all entries are lost, and out_valid=0 and in_ready=1 the cycle after rst.
- A simultaneous flush and out_fire counts as a flush; the downstream consumer must qualify with its own flush.
- in_valid may toggle freely. in_data/in_ctrl are sampled only on in_fire.
- Reset values of every output: in_ready=1, out_valid=0, out_data=0, out_ctrl=0, occupancy=0.

Optional Feature:
PIPE_STAGE_PERF_EN
- Defined:
  - Adds outputs stall_cnt[CNT_W-1:0], counting cycles with out_valid & !out_ready.
  - Adds outputs bubble_cnt[CNT_W-1:0], counting cycles with !out_valid.
  - Both counters saturate at all-ones, clear only on rst (not on flush), and read 0 after reset.
- Undefined: the ports and counters are absent; the remaining behaviour is identical.

Test Plan:
1. Streaming: rst for 2 cycles, then in_valid=1 with in_data=0x100,0x104,0x108 on consecutive cycles, out_ready=1 → out_data=0x100,0x104,0x108 on cycles 1..3 after each accept; occupancy=1 throughout; in_ready stays 1.
2. Stall/skid: accept 0xA, drop out_ready, present 0xB then 0xC → 0xB taken into skid, in_ready=0, occupancy=2, 0xC held off upstream. Raise out_ready → outputs 0xA, 0xB, 0xC in order with no loss.
3. Bubble gating: in_ctrl=0xFFFF, in_valid=0 for 3 cycles → out_valid=0 and out_ctrl=0x0000. With PERF_EN, bubble_cnt=3.
4. Flush: occupancy=2 (0x1, 0x2), assert flush together with in_valid and in_data=0x3 → next cycle occupancy=0, out_ctrl=0, in_ready=1, and 0x3 never appears at the output.
5. Reset priority: rst=1 and flush=1 while occupancy=2 → next cycle all outputs equal their reset values. Release rst and accept 0x55 → 0x55 appears 1 cycle later.
6. Saturation (PERF_EN, CNT_W=4): hold out_valid=1 and out_ready=0 for 20 cycles → stall_cnt=0xF and remains 0xF.

Source files
------------

// File: rtl/pipe_stage_elastic_if.sv
// Handshake bundle between two pipeline stages: upstream entry, downstream head,
// flush request and occupancy. The stage uses the slave view, its environment the master view.
interface pipe_stage_elastic_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
);

  // Valid/ready: an entry moves exactly on a cycle where valid and ready are both 1
  // at the rising edge; data/ctrl are only meaningful while valid is 1, and a valid
  // producer keeps its entry stable until it has been taken.
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;

  modport master (
    output flush,
    output in_valid,
    output in_data,
    output in_ctrl,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_ctrl,
    input  occupancy
  );

  modport slave (
    input  flush,
    input  in_valid,
    input  in_data,
    input  in_ctrl,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_ctrl,
    output occupancy
  );

endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage pipeline register: head + skid entry, valid/ready back-pressure,
// synchronous flush, bubble-gated control. Optional counters under PIPE_STAGE_PERF_EN.
module pipe_stage_elastic #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  pipe_stage_elastic_if.slave     bus
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        bubble_cnt
`endif
);

  if (DATA_W < 1 || CTRL_W < 1 || CNT_W < 1) begin : g_bad_param
    $error("pipe_stage_elastic: DATA_W, CTRL_W and CNT_W must all be at least 1");
  end

  // State encoding doubles as the entry count, so occupancy is the state itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e            state_q,     state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              in_ready_q,  in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic in_fire;
  logic out_fire;

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    // Flush drops every held entry and any entry offered in the same cycle; only
    // ctrl is cleared so a stale head can never assert a write downstream.
    if (bus.flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d     = ST_ONE;
            main_data_d = bus.in_data;
            main_ctrl_d = bus.in_ctrl;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_data_d = bus.in_data;
            main_ctrl_d = bus.in_ctrl;
          end else if (in_fire) begin
            state_d     = ST_TWO;
            skid_data_d = bus.in_data;
            skid_ctrl_d = bus.in_ctrl;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state_d     = ST_ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end

    // Handshake outputs are computed from the next state and registered, which keeps
    // out_ready off any combinational path to in_ready.
    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_data_q;
  assign bus.out_ctrl  = main_ctrl_q & {CTRL_W{out_valid_q}};
  assign bus.occupancy = state_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating counters; flush leaves them untouched so stalls across a flush still count.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (out_valid_q && !bus.out_ready && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (!out_valid_q && !(&bubble_cnt_q)) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: a negedge monitor scoreboards every accepted
// entry against the head, while the main thread checks flags at hand-computed points.
module tb_pipe_stage_elastic;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 16;
  localparam int W      = DATA_W + CTRL_W;
`ifdef PIPE_STAGE_PERF_EN
  localparam int CNT_W  = 4;
`else
  localparam int CNT_W  = 32;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_stage_elastic_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;
`endif

  pipe_stage_elastic #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Outputs are compared before the accepted input is queued: a new entry can never
  // reach the head in the cycle it is accepted.
  always @(negedge clk) begin
    if (rst || bus.flush) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_out: got entry 0x%0h, expected none (t=%0t)", bus.out_data, $time);
        end else begin
          mon_exp = exp_q.pop_front();
          check("out_entry", 64'({bus.out_ctrl, bus.out_data}), 64'(mon_exp));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back({bus.in_ctrl, bus.in_data});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_ctrl  = c;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  64'(bus.in_ready),  64'h1);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'h0);
    check({tag, "_out_data"},  64'(bus.out_data),  64'h0);
    check({tag, "_out_ctrl"},  64'(bus.out_ctrl),  64'h0);
    check({tag, "_occupancy"}, 64'(bus.occupancy), 64'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, '0, '0);
    repeat (2) step();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Streaming at one entry per cycle
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h100, 16'h0011);
    check("stream_in_ready0", 64'(bus.in_ready), 64'h1);
    step();
    check("stream_occ0", 64'(bus.occupancy), 64'h1);
    check("stream_head0", 64'(bus.out_data), 64'h100);
    drive(1'b1, 32'h104, 16'h0012);
    step();
    check("stream_occ1", 64'(bus.occupancy), 64'h1);
    check("stream_in_ready1", 64'(bus.in_ready), 64'h1);
    check("stream_head1", 64'(bus.out_data), 64'h104);
    drive(1'b1, 32'h108, 16'h0013);
    step();
    check("stream_occ2", 64'(bus.occupancy), 64'h1);
    check("stream_head2", 64'(bus.out_data), 64'h108);
    drive(1'b0, '0, '0);
    step();
    check("stream_drained", 64'(bus.occupancy), 64'h0);

    // Stall and skid
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hA, 16'h00A0);
    step();
    check("skid_occ1", 64'(bus.occupancy), 64'h1);
    check("skid_in_ready1", 64'(bus.in_ready), 64'h1);
    drive(1'b1, 32'hB, 16'h00B0);
    step();
    check("skid_occ2", 64'(bus.occupancy), 64'h2);
    check("skid_in_ready2", 64'(bus.in_ready), 64'h0);
    check("skid_head_a", 64'(bus.out_data), 64'hA);
    drive(1'b1, 32'hC, 16'h00C0);
    step();
    step();
    check("skid_hold_occ", 64'(bus.occupancy), 64'h2);
    check("skid_hold_data", 64'(bus.out_data), 64'hA);
    check("skid_hold_ctrl", 64'(bus.out_ctrl), 64'h00A0);
    bus.out_ready = 1'b1;
    step();
    check("skid_head_b", 64'(bus.out_data), 64'hB);
    check("skid_reopen", 64'(bus.in_ready), 64'h1);
    step();
    check("skid_head_c", 64'(bus.out_data), 64'hC);
    drive(1'b0, '0, '0);
    step();
    check("skid_drained", 64'(bus.occupancy), 64'h0);

    // Bubble gating of control
    drive(1'b0, 32'hDEAD, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bubble_valid", 64'(bus.out_valid), 64'h0);
      check("bubble_ctrl", 64'(bus.out_ctrl), 64'h0);
    end

    // Flush from TWO with an entry offered
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h1, 16'h0101);
    step();
    drive(1'b1, 32'h2, 16'h0202);
    step();
    check("flush_pre_occ", 64'(bus.occupancy), 64'h2);
    bus.flush = 1'b1;
    drive(1'b1, 32'h3, 16'h0303);
    step();
    bus.flush = 1'b0;
    drive(1'b0, '0, '0);
    check("flush_occ", 64'(bus.occupancy), 64'h0);
    check("flush_valid", 64'(bus.out_valid), 64'h0);
    check("flush_ctrl", 64'(bus.out_ctrl), 64'h0);
    check("flush_in_ready", 64'(bus.in_ready), 64'h1);
    check("flush_data_held", 64'(bus.out_data), 64'h1);

    // Flush from ONE while an entry actually fires
    drive(1'b1, 32'h7, 16'h0707);
    step();
    bus.flush = 1'b1;
    drive(1'b1, 32'h8, 16'h0808);
    step();
    bus.flush = 1'b0;
    drive(1'b0, '0, '0);
    check("flush1_occ", 64'(bus.occupancy), 64'h0);
    check("flush1_data_held", 64'(bus.out_data), 64'h7);
    bus.out_ready = 1'b1;
    repeat (2) step();

    // Reset beats flush while full
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h11, 16'h1111);
    step();
    drive(1'b1, 32'h22, 16'h2222);
    step();
    check("rst_pre_occ", 64'(bus.occupancy), 64'h2);
    rst       = 1'b1;
    bus.flush = 1'b1;
    drive(1'b1, 32'h99, 16'h9999);
    step();
    rst       = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, '0, '0);
    check_reset_outputs("midrst");
`ifdef PIPE_STAGE_PERF_EN
    check("perf_stall_rst", 64'(stall_cnt), 64'h0);
    check("perf_bubble_rst", 64'(bubble_cnt), 64'h0);
`endif
    repeat (3) step();
`ifdef PIPE_STAGE_PERF_EN
    check("perf_bubble3", 64'(bubble_cnt), 64'h3);
`endif
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h55, 16'h1234);
    step();
    drive(1'b0, '0, '0);
    check("post_rst_valid", 64'(bus.out_valid), 64'h1);
    check("post_rst_data", 64'(bus.out_data), 64'h55);
    check("post_rst_ctrl", 64'(bus.out_ctrl), 64'h1234);
    step();
    check("post_rst_drained", 64'(bus.occupancy), 64'h0);

`ifdef PIPE_STAGE_PERF_EN
    // Stall counter saturation
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h66, 16'h0066);
    step();
    drive(1'b0, '0, '0);
    repeat (20) step();
    check("perf_stall_sat", 64'(stall_cnt), 64'hF);
    repeat (2) step();
    check("perf_stall_sat_hold", 64'(stall_cnt), 64'hF);
    bus.out_ready = 1'b1;
    repeat (2) step();
`endif

    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
